fetch_stage: RTL and testbench

//  Instruction-fetch stage of the RV32IM 5-stage pipeline; directly feeds decode_stage with instruction + PC.

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_buffer.sv | 54 +++++
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Holds the NOP encoding, reset vector and the fetch-buffer entry layout.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small {pc, instr} FIFO between instruction memory and decode.
// Flush empties it in one cycle; head entry is visible combinationally.
module fetch_buffer #(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && full && !flush));

endmodule

// File: rtl/fetch_stage.sv
// RV32IM fetch stage: PC, credit-limited issue to imem, stale-response
// dropping after redirects, and the buffered hand-off to decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_VECTOR,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instruction
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(BUF_DEPTH);

    logic [31:0]   pc;
    logic          running;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop_cnt;
    logic [31:0]   tag_mem [BUF_DEPTH];
    logic [AW-1:0] tag_wr;
    logic [AW-1:0] tag_rd;

    logic          grant;
    logic          drop_rsp;
    logic          push;
    logic          pop;
    logic [63:0]   buf_rdata;
    logic [CW-1:0] buf_count;
    logic          buf_empty;
    logic          buf_full;
    fetch_entry_t  head;

    // running holds off the first request until the cycle after reset release
    assign imem_req = running && !redirect &&
        (({1'b0, outstanding} + {1'b0, buf_count}) < CREDITS);
    assign imem_addr = pc;

    assign grant    = imem_req && imem_gnt;
    assign drop_rsp = imem_rvalid && (drop_cnt != '0);
    assign push     = imem_rvalid && !drop_rsp && !redirect;
    assign pop      = !buf_empty && !stall && !redirect;

    assign outstanding_next = outstanding + CW'(grant) - CW'(imem_rvalid);

    always_ff @(posedge clk) begin
        if (grant)
            tag_mem[tag_wr] <= pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            running     <= 1'b0;
            outstanding <= '0;
            drop_cnt    <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
        end else begin
            running     <= 1'b1;
            outstanding <= outstanding_next;
            if (redirect) begin
                pc       <= align_word(redirect_pc);
                drop_cnt <= outstanding_next;
                tag_wr   <= '0;
                tag_rd   <= '0;
            end else begin
                if (grant) begin
                    pc     <= pc + 32'd4;
                    tag_wr <= tag_wr + AW'(1);
                end
                if (push)
                    tag_rd <= tag_rd + AW'(1);
                drop_cnt <= drop_cnt - CW'(drop_rsp);
            end
        end
    end

    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({tag_mem[tag_rd], imem_rdata}),
        .rdata (buf_rdata),
        .count (buf_count),
        .empty (buf_empty),
        .full  (buf_full)
    );

    assign head           = fetch_entry_t'(buf_rdata);
    assign if_valid       = !buf_empty;
    assign if_pc          = buf_empty ? pc : head.pc;
    assign if_instruction = buf_empty ? NOP_INSTR : head.instr;
    assign if_pc_plus4    = if_pc + 32'd4;

    a_redirect_aligned: assert property (@(posedge clk) disable iff (!rst)
        redirect |-> (redirect_pc[1:0] == 2'b00));
    a_drop_le_out: assert property (@(posedge clk) disable iff (!rst)
        drop_cnt <= outstanding);
    a_full_no_req: assert property (@(posedge clk) disable iff (!rst)
        buf_full |-> !imem_req);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: queue-based memory and
// fetch reference model, randomized stall/grant/latency/redirect.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instruction;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .if_instruction (if_instruction)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] m_tags[$];
    logic [31:0] m_fifo[$];
    logic [31:0] m_pc;
    bit          m_run;
    int          m_out;
    int          m_drop;
    int          cyc;
    int          last_due;
    int          lat_min;
    int          lat_max;
    int          gnt_pct;
    bit          obs_req;
    bit          exp_req;
    logic [31:0] obs_addr;
    logic [31:0] exp_addr;
    int          total;
    int          bad;

    task automatic model_reset();
        pend.delete();
        m_tags.delete();
        m_fifo.delete();
        m_pc     = 32'h0;
        m_run    = 1'b0;
        m_out    = 0;
        m_drop   = 0;
        last_due = 0;
    endtask

    // One clock: drive inputs at negedge, advance model, return at next negedge
    task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
        bit          g;
        bit          rv;
        bit          had;
        logic [31:0] raddr;
        logic [31:0] tag;
        int          due;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        g  = ($urandom_range(99) < gnt_pct);
        rv = (pend.size() > 0) && (pend[0].due <= cyc);
        raddr = 32'h0;
        if (rv) begin
            raddr = pend[0].addr;
            void'(pend.pop_front());
        end
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rv ? (raddr ^ KEY) : $urandom;
        exp_req  = m_run && !rd && ((m_out + m_fifo.size()) < 2);
        exp_addr = m_pc;
        #1;
        obs_req  = imem_req;
        obs_addr = imem_addr;
        if (exp_req && g) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due < last_due)
                due = last_due;
            last_due = due;
            pend.push_back('{m_pc, due});
        end
        had = (m_fifo.size() > 0);
        if (rv) begin
            m_out--;
            if (m_drop > 0) begin
                m_drop--;
            end else begin
                tag = m_tags.pop_front();
                if (!rd)
                    m_fifo.push_back(tag);
            end
        end
        if (rd) begin
            m_fifo.delete();
            m_tags.delete();
            m_pc   = rpc & ~32'd3;
            m_drop = m_out;
        end else begin
            if (had && !st)
                void'(m_fifo.pop_front());
            if (exp_req && g) begin
                m_tags.push_back(m_pc);
                m_pc = m_pc + 32'd4;
                m_out++;
            end
        end
        m_run = 1'b1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        total++;
        if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl valid=%b req=%b need 0 0", if_valid, imem_req);
        end
        total++;
        if (if_pc !== 32'h0 || if_pc_plus4 !== 32'h4) begin
            bad++;
            $display("FAIL reset_pc pc=%h p4=%h need 0 4", if_pc, if_pc_plus4);
        end
        total++;
        if (if_instruction !== NOP) begin
            bad++;
            $display("FAIL reset_instr got=%h need=%h", if_instruction, NOP);
        end
    endtask

    task automatic test_zero_latency();
        logic [31:0] seq;
        gnt_pct = 100;
        lat_min = 1;
        lat_max = 1;
        seq = 32'h0;
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b0, 32'h0);
            total++;
            if (obs_req !== exp_req || (exp_req && obs_addr !== exp_addr)) begin
                bad++;
                $display("FAIL zl_req req=%b addr=%h need %b %h",
                         obs_req, obs_addr, exp_req, exp_addr);
            end
            if (if_valid) begin
                total++;
                if (if_pc !== seq || if_instruction !== (seq ^ KEY) ||
                    if_pc_plus4 !== seq + 32'd4) begin
                    bad++;
                    $display("FAIL zl_seq pc=%h ins=%h need %h %h",
                             if_pc, if_instruction, seq, seq ^ KEY);
                end
                seq = seq + 32'd4;
            end
        end
        total++;
        if (seq < 32'd40) begin
            bad++;
            $display("FAIL zl_progress delivered_to=%h need>=%h", seq, 32'd40);
        end
    endtask

    task automatic test_latency3();
        gnt_pct = 100;
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 30; i++) begin
            step(($urandom_range(3) == 0), 1'b0, 32'h0);
            total++;
            if (obs_req !== exp_req || (exp_req && obs_addr !== exp_addr)) begin
                bad++;
                $display("FAIL l3_req req=%b addr=%h need %b %h",
                         obs_req, obs_addr, exp_req, exp_addr);
            end
            total++;
            if (if_valid !== (m_fifo.size() != 0) ||
                (if_valid && if_pc !== m_fifo[0])) begin
                bad++;
                $display("FAIL l3_out valid=%b pc=%h need %b %h",
                         if_valid, if_pc, m_fifo.size() != 0,
                         m_fifo.size() != 0 ? m_fifo[0] : 32'h0);
            end
        end
    endtask

    task automatic test_stall_full();
        logic [31:0] held_pc;
        logic [31:0] held_ins;
        int          n;
        gnt_pct = 100;
        lat_min = 1;
        lat_max = 1;
        n = 0;
        while (m_fifo.size() < 2 && n < 12) begin
            step(1'b1, 1'b0, 32'h0);
            n++;
        end
        total++;
        if (if_valid !== 1'b1 || m_fifo.size() != 2) begin
            bad++;
            $display("FAIL sf_fill valid=%b need 1 (model size %0d)", if_valid, m_fifo.size());
        end
        held_pc  = m_fifo[0];
        held_ins = m_fifo[0] ^ KEY;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 32'h0);
            total++;
            if (obs_req !== 1'b0 || if_pc !== held_pc || if_instruction !== held_ins) begin
                bad++;
                $display("FAIL sf_hold req=%b pc=%h ins=%h need 0 %h %h",
                         obs_req, if_pc, if_instruction, held_pc, held_ins);
            end
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'h0);
            total++;
            if (if_valid !== (m_fifo.size() != 0) ||
                (if_valid && if_pc !== m_fifo[0])) begin
                bad++;
                $display("FAIL sf_resume valid=%b pc=%h need %b %h", if_valid, if_pc,
                         m_fifo.size() != 0, m_fifo.size() != 0 ? m_fifo[0] : 32'h0);
            end
        end
        total++;
        if (m_fifo.size() != 0 && if_pc !== held_pc + 32'd4 * (m_fifo[0] - held_pc) / 32'd4) begin
            bad++;
            $display("FAIL sf_order pc=%h", if_pc);
        end
    endtask

    task automatic wait_first_valid(input logic [31:0] target, input string name);
        int n;
        n = 0;
        while (!if_valid && n < 20) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        total++;
        if (if_valid !== 1'b1 || if_pc !== target || if_instruction !== (target ^ KEY)) begin
            bad++;
            $display("FAIL %s valid=%b pc=%h ins=%h need 1 %h %h",
                     name, if_valid, if_pc, if_instruction, target, target ^ KEY);
        end
    endtask

    task automatic test_redirect();
        int n;
        gnt_pct = 100;
        lat_min = 3;
        lat_max = 3;
        n = 0;
        while (m_out < 2 && n < 10) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        total++;
        if (m_out != 2) begin
            bad++;
            $display("FAIL rd_setup outstanding=%0d need 2", m_out);
        end
        step(1'b0, 1'b1, 32'h0000_0100);
        total++;
        if (obs_req !== 1'b0 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL rd_cycle req=%b valid=%b need 0 0", obs_req, if_valid);
        end
        wait_first_valid(32'h0000_0100, "rd_target");
    endtask

    task automatic test_redirect_rvalid_stall();
        int n;
        gnt_pct = 100;
        lat_min = 2;
        lat_max = 2;
        n = 0;
        while (!(pend.size() > 0 && pend[0].due <= cyc && m_fifo.size() > 0) && n < 20) begin
            step(1'b1, 1'b0, 32'h0);
            n++;
        end
        total++;
        if (!(pend.size() > 0 && pend[0].due <= cyc)) begin
            bad++;
            $display("FAIL rrs_setup no response due after %0d cycles", n);
        end
        step(1'b1, 1'b1, 32'h0000_0200);
        total++;
        if (if_valid !== 1'b0 || if_instruction !== NOP) begin
            bad++;
            $display("FAIL rrs_flush valid=%b ins=%h need 0 %h", if_valid, if_instruction, NOP);
        end
        wait_first_valid(32'h0000_0200, "rrs_target");
    endtask

    task automatic test_random();
        bit          rd;
        logic [31:0] tgt;
        for (int i = 0; i < 400; i++) begin
            gnt_pct = 60 + $urandom_range(40);
            lat_min = 1;
            lat_max = 4;
            rd  = ($urandom_range(99) < 6);
            tgt = $urandom & 32'h0000_0FFC;
            step(($urandom_range(99) < 30), rd, tgt);
            total++;
            if (obs_req !== exp_req || (exp_req && obs_addr !== exp_addr)) begin
                bad++;
                $display("FAIL rnd_req cyc=%0d req=%b addr=%h need %b %h",
                         cyc, obs_req, obs_addr, exp_req, exp_addr);
            end
            total++;
            if (if_valid !== (m_fifo.size() != 0)) begin
                bad++;
                $display("FAIL rnd_valid cyc=%0d got=%b need=%b", cyc, if_valid, m_fifo.size() != 0);
            end else if (if_valid) begin
                total++;
                if (if_pc !== m_fifo[0] || if_instruction !== (m_fifo[0] ^ KEY) ||
                    if_pc_plus4 !== m_fifo[0] + 32'd4) begin
                    bad++;
                    $display("FAIL rnd_data cyc=%0d pc=%h ins=%h need %h %h",
                             cyc, if_pc, if_instruction, m_fifo[0], m_fifo[0] ^ KEY);
                end
            end
        end
    endtask

    task automatic test_reset_mid_and_wrap();
        bit          saw_top;
        bit          saw_wrap;
        gnt_pct = 100;
        lat_min = 2;
        lat_max = 2;
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        test_reset();
        model_reset();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        stall       = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        total++;
        if (obs_req !== 1'b0) begin
            bad++;
            $display("FAIL rst_rel_req req=%b need 0", obs_req);
        end
        step(1'b0, 1'b0, 32'h0);
        total++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
            bad++;
            $display("FAIL rst_restart req=%b addr=%h need 1 0", obs_req, obs_addr);
        end
        step(1'b0, 1'b1, 32'hFFFF_FFF8);
        saw_top  = 1'b0;
        saw_wrap = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (if_valid && if_pc === 32'hFFFF_FFFC) begin
                saw_top = 1'b1;
                total++;
                if (if_pc_plus4 !== 32'h0) begin
                    bad++;
                    $display("FAIL wrap_p4 got=%h need 0", if_pc_plus4);
                end
            end
            if (if_valid && saw_top && if_pc === 32'h0)
                saw_wrap = 1'b1;
        end
        total++;
        if (!(saw_top && saw_wrap)) begin
            bad++;
            $display("FAIL wrap_seq top=%b zero=%b need 1 1", saw_top, saw_wrap);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        cyc         = 0;
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        gnt_pct     = 100;
        lat_min     = 1;
        lat_max     = 1;
        model_reset();
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        test_zero_latency();
        test_latency3();
        test_stall_full();
        test_redirect();
        test_redirect_rvalid_stall();
        test_random();
        test_reset_mid_and_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
